instr_fetch_seq: RTL and testbench



---
 rtl/instr_fetch_seq_pkg.sv | 19 +
 rtl/instr_fetch_seq_if.sv | 15 +
 rtl/instr_fetch_seq_decode.sv | 34 +++
 rtl/instr_fetch_seq.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_seq.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch/decode sequencer.
package instr_fetch_seq_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_DECODE = 3'd2,
    S_STEP   = 3'd3,
    S_HALT   = 3'd4
  } state_e;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Instruction memory read port: req/addr out, ack/rdata back in the same cycle.
interface instr_fetch_seq_if
  import instr_fetch_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/instr_fetch_seq_decode.sv
// Control-flow opcode decode: opcode + zero flag -> jump request, offset, halt.
module instr_decode
  import instr_fetch_seq_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic [3:0]    op,
  input  logic [AW-1:0] field,
  input  logic          zero_flag,
  output logic          jmp,
  output logic [AW-1:0] offset,
  output logic          is_halt
);

  // Non-jump opcodes (and untaken JZ) leave offset at zero so the PC sees a clean +1.
  always_comb begin
    jmp     = 1'b0;
    offset  = '0;
    is_halt = 1'b0;
    case (op)
      OP_HALT: is_halt = 1'b1;
      OP_JMP: begin
        jmp    = 1'b1;
        offset = field;
      end
      OP_JZ: if (zero_flag) begin
        jmp    = 1'b1;
        offset = field;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch/decode sequencer: IDLE -> REQ -> DECODE -> STEP -> REQ ..., HALT on
// HALT opcode or memory timeout. All outputs are registered.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       pc,
  input  logic                zero_flag,
  instr_fetch_seq_if.master   mem,
  output logic [DW-1:0]       ir,
  output logic                jmp,
  output logic [AW-1:0]       offset,
  output logic                pc_step,
  output logic                halted,
  output logic                fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          jmp_q, jmp_d;
  logic [AW-1:0] off_q, off_d;
  logic          step_q, step_d;
  logic          halted_q, halted_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          dec_jmp, dec_halt;
  logic [AW-1:0] dec_off;

  instr_decode #(.AW(AW)) u_dec (
    .op        (ir_q[DW-1:DW-4]),
    .field     (ir_q[AW-1:0]),
    .zero_flag (zero_flag),
    .jmp       (dec_jmp),
    .offset    (dec_off),
    .is_halt   (dec_halt)
  );

  // Next-state logic. The fetch address for the following instruction is
  // formed in STEP as the value the PC takes on that same edge, so REQ
  // starts with the updated PC already on mem_addr.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    ir_d     = ir_q;
    jmp_d    = jmp_q;
    off_d    = off_q;
    step_d   = 1'b0;
    halted_d = halted_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        req_d   = 1'b1;
        addr_d  = pc;
        cnt_d   = '0;
      end
      S_REQ: begin
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          cnt_d   = '0;
          req_d   = 1'b0;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            fault_d  = 1'b1;
            halted_d = 1'b1;
            req_d    = 1'b0;
            state_d  = S_HALT;
          end
        end
      end
      S_DECODE: begin
        if (dec_halt) begin
          halted_d = 1'b1;
          jmp_d    = 1'b0;
          off_d    = '0;
          state_d  = S_HALT;
        end else begin
          jmp_d   = dec_jmp;
          off_d   = dec_off;
          step_d  = 1'b1;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        jmp_d   = 1'b0;
        off_d   = '0;
        req_d   = 1'b1;
        addr_d  = pc + (jmp_q ? off_q : AW'(1));
        state_d = S_REQ;
      end
      S_HALT: begin
        req_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops mem_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      ir_q     <= '0;
      jmp_q    <= 1'b0;
      off_q    <= '0;
      step_q   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      ir_q     <= ir_d;
      jmp_q    <= jmp_d;
      off_q    <= off_d;
      step_q   <= step_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign ir           = ir_q;
  assign jmp          = jmp_q;
  assign offset       = off_q;
  assign pc_step      = step_q;
  assign halted       = halted_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench: a table of fetched instructions with hand-computed
// jump/offset/next-address results, plus hand sequences for HALT, reset
// mid-request and memory timeout. The PC block is modelled here.
module tb_instr_fetch_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pc, pc_rst;
  logic       zero_flag;
  logic [7:0] ir;
  logic       jmp, pc_step, halted, fault;
  logic [3:0] offset;

  int n_chk  = 0;
  int n_pass = 0;

  instr_fetch_seq_if #(.AW(4), .DW(8)) mif ();

  instr_fetch_seq #(.AW(4), .DW(8), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .zero_flag (zero_flag),
    .mem       (mif.master),
    .ir        (ir),
    .jmp       (jmp),
    .offset    (offset),
    .pc_step   (pc_step),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // PC block: updates on the pc_step edge.
  always @(posedge clk or negedge rst_n)
    if (!rst_n)       pc <= pc_rst;
    else if (pc_step) pc <= jmp ? pc + offset : pc + 4'd1;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] instr;
    logic       zf;
    int         waits;
    logic       jmp;
    logic [3:0] off;
    logic [3:0] nxt;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 30 && mif.mem_req !== 1'b1; i++) @(negedge clk);
    chk("req_seen", {31'd0, mif.mem_req}, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},    {31'd0, mif.mem_req}, 0);
    chk({tag, "_addr"},   {28'd0, mif.mem_addr}, 0);
    chk({tag, "_ir"},     {24'd0, ir}, 0);
    chk({tag, "_jmp"},    {31'd0, jmp}, 0);
    chk({tag, "_off"},    {28'd0, offset}, 0);
    chk({tag, "_step"},   {31'd0, pc_step}, 0);
    chk({tag, "_halted"}, {31'd0, halted}, 0);
    chk({tag, "_fault"},  {31'd0, fault}, 0);
  endtask

  initial begin
    logic [7:0] prev_ir;
    logic       bad;
    int         n;

    tbl[0] = '{4'h3, 8'h12, 1'b0, 0, 1'b0, 4'h0, 4'h4};
    tbl[1] = '{4'h4, 8'hFE, 1'b0, 0, 1'b1, 4'hE, 4'h2};
    tbl[2] = '{4'h2, 8'hF5, 1'b0, 0, 1'b1, 4'h5, 4'h7};
    tbl[3] = '{4'h7, 8'hE3, 1'b1, 0, 1'b1, 4'h3, 4'hA};
    tbl[4] = '{4'hA, 8'hE3, 1'b0, 0, 1'b0, 4'h0, 4'hB};
    tbl[5] = '{4'hB, 8'h25, 1'b1, 0, 1'b0, 4'h0, 4'hC};
    tbl[6] = '{4'hC, 8'hF9, 1'b0, 0, 1'b1, 4'h9, 4'h5};
    tbl[7] = '{4'h5, 8'hF0, 1'b0, 0, 1'b1, 4'h0, 4'h5};
    tbl[8] = '{4'h5, 8'hE7, 1'b0, 0, 1'b0, 4'h0, 4'h6};
    tbl[9] = '{4'h6, 8'h3A, 1'b0, 4, 1'b0, 4'h0, 4'h7};

    rst_n         = 1'b0;
    pc_rst        = 4'h3;
    zero_flag     = 1'b0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 8'hAA;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    rst_n = 1'b1;

    prev_ir = 8'h00;
    for (int v = 0; v < 10; v++) begin
      wait_req();
      chk($sformatf("v%0d_addr", v), {28'd0, mif.mem_addr}, {28'd0, tbl[v].addr});
      for (int w = 0; w < tbl[v].waits; w++) begin
        mif.mem_ack = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_w%0d_req", v, w), {31'd0, mif.mem_req}, 1);
        chk($sformatf("v%0d_w%0d_addr", v, w), {28'd0, mif.mem_addr}, {28'd0, tbl[v].addr});
        chk($sformatf("v%0d_w%0d_ir", v, w), {24'd0, ir}, {24'd0, prev_ir});
      end
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = tbl[v].instr;
      zero_flag     = tbl[v].zf;
      @(negedge clk);
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = 8'hAA;
      chk($sformatf("v%0d_ir", v), {24'd0, ir}, {24'd0, tbl[v].instr});
      chk($sformatf("v%0d_dec_req", v), {31'd0, mif.mem_req}, 0);
      chk($sformatf("v%0d_dec_step", v), {31'd0, pc_step}, 0);
      @(negedge clk);
      chk($sformatf("v%0d_step", v), {31'd0, pc_step}, 1);
      chk($sformatf("v%0d_jmp", v), {31'd0, jmp}, {31'd0, tbl[v].jmp});
      chk($sformatf("v%0d_off", v), {28'd0, offset}, {28'd0, tbl[v].off});
      chk($sformatf("v%0d_step_req", v), {31'd0, mif.mem_req}, 0);
      @(negedge clk);
      chk($sformatf("v%0d_step_clr", v), {31'd0, pc_step}, 0);
      chk($sformatf("v%0d_jmp_clr", v), {28'd0, jmp, offset}, 0);
      chk($sformatf("v%0d_next_req", v), {31'd0, mif.mem_req}, 1);
      chk($sformatf("v%0d_next_addr", v), {28'd0, mif.mem_addr}, {28'd0, tbl[v].nxt});
      chk($sformatf("v%0d_fault", v), {30'd0, fault, halted}, 0);
      prev_ir = tbl[v].instr;
    end

    // HALT opcode at address 7: stops for good, later acks ignored.
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 8'h07;
    @(negedge clk);
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 8'hAA;
    chk("halt_dec_halted", {31'd0, halted}, 0);
    @(negedge clk);
    chk("halt_halted", {31'd0, halted}, 1);
    chk("halt_fault", {31'd0, fault}, 0);
    mif.mem_ack = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mif.mem_req !== 1'b0 || pc_step !== 1'b0 || jmp !== 1'b0 ||
          ir !== 8'h07 || halted !== 1'b1) bad = 1'b1;
    end
    mif.mem_ack = 1'b0;
    chk("halt_quiet", {31'd0, bad}, 0);

    // Reset mid-REQ: mem_req drops asynchronously, restart through IDLE.
    pc_rst = 4'h9;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_req();
    chk("rq_addr", {28'd0, mif.mem_addr}, 32'h9);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rq_async_req", {31'd0, mif.mem_req}, 0);
    chk("rq_async_halted", {31'd0, halted}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rq_restart_req", {31'd0, mif.mem_req}, 1);
    chk("rq_restart_addr", {28'd0, mif.mem_addr}, 32'h9);

    // No ack: 15 REQ cycles then fault.
    n = 0;
    while (mif.mem_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_len", n, 15);
    chk("to_fault", {31'd0, fault}, 1);
    chk("to_halted", {31'd0, halted}, 1);
    chk("to_req", {31'd0, mif.mem_req}, 0);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 8'h5C;
    repeat (3) @(negedge clk);
    chk("to_ack_ir", {24'd0, ir}, 0);
    chk("to_ack_req", {31'd0, mif.mem_req}, 0);
    mif.mem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("to_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
